// File: rtl/fp_intermediate_wb_arbiter_if.sv
// Handshake bundle between the FP producer units, the intermediate-writeback
// arbiter and the shared normalization/rounding stage.
interface fp_intermediate_wb_arbiter_if #(
    parameter int NUM_UNITS = 3,
    parameter int ID_W      = 3,
    parameter int PAYLOAD_W = 128
);
    localparam int SRC_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]           unit_done;
    logic [NUM_UNITS*ID_W-1:0]      unit_id;
    logic [NUM_UNITS*PAYLOAD_W-1:0] unit_payload;
    logic [NUM_UNITS-1:0]           unit_ack;
    logic                           norm_valid;
    logic                           norm_ready;
    logic [ID_W-1:0]                norm_id;
    logic [PAYLOAD_W-1:0]           norm_payload;
    logic [SRC_W-1:0]               norm_src;

    // Producers plus normalization stage side
    modport master (
        output unit_done, unit_id, unit_payload, norm_ready,
        input  unit_ack, norm_valid, norm_id, norm_payload, norm_src
    );

    // Arbiter side
    modport slave (
        input  unit_done, unit_id, unit_payload, norm_ready,
        output unit_ack, norm_valid, norm_id, norm_payload, norm_src
    );
endinterface

// File: rtl/fp_intermediate_wb_arbiter.sv
// Round-robin arbiter acking FP producers into a 2-entry buffer feeding normalization.
// Define FP_WB_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins, no pointer).
module fp_intermediate_wb_arbiter #(
    parameter int NUM_UNITS = 3,
    parameter int ID_W      = 3,
    parameter int PAYLOAD_W = 128
) (
    input logic                         clk,
    input logic                         rst,
    fp_intermediate_wb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_UNITS);

    logic [1:0]           count_q;
    logic [ID_W-1:0]      head_id_q, tail_id_q;
    logic [PAYLOAD_W-1:0] head_pay_q, tail_pay_q;
    logic [SRC_W-1:0]     head_src_q, tail_src_q;

    logic                 pop;
    logic                 push;
    logic                 space;
    logic                 gnt_found;
    logic [SRC_W-1:0]     gnt_idx;
    logic [ID_W-1:0]      push_id;
    logic [PAYLOAD_W-1:0] push_pay;

    assign bus.norm_valid   = (count_q != 2'd0);
    assign bus.norm_id      = head_id_q;
    assign bus.norm_payload = head_pay_q;
    assign bus.norm_src     = head_src_q;

    assign pop   = bus.norm_valid & bus.norm_ready;
    assign space = (count_q != 2'd2) | pop;
    // Gating with rst keeps ack low for the whole reset, not just after the next edge
    assign push  = space & gnt_found & rst;
    assign bus.unit_ack = push ? (NUM_UNITS'(1) << gnt_idx) : '0;

    // ---- Grant select ----
`ifdef FP_WB_ARB_FIXED_PRIORITY_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        push_id   = '0;
        push_pay  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!gnt_found && bus.unit_done[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(i);
                push_id   = bus.unit_id[i*ID_W +: ID_W];
                push_pay  = bus.unit_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end
`else
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_UNITS - 1);

    logic [SRC_W-1:0] rr_ptr_q;

    // First pass covers indices at/above the pointer, second pass the wrapped range
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        push_id   = '0;
        push_pay  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!gnt_found && bus.unit_done[i] && (SRC_W'(i) >= rr_ptr_q)) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(i);
                push_id   = bus.unit_id[i*ID_W +: ID_W];
                push_pay  = bus.unit_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!gnt_found && bus.unit_done[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(i);
                push_id   = bus.unit_id[i*ID_W +: ID_W];
                push_pay  = bus.unit_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else if (push) begin
            rr_ptr_q <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    // ---- Output buffer: head feeds norm_* directly, tail holds the second entry ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            head_id_q  <= '0;
            head_pay_q <= '0;
            head_src_q <= '0;
            tail_id_q  <= '0;
            tail_pay_q <= '0;
            tail_src_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_id_q  <= push_id;
                        head_pay_q <= push_pay;
                        head_src_q <= gnt_idx;
                    end else begin
                        tail_id_q  <= push_id;
                        tail_pay_q <= push_pay;
                        tail_src_q <= gnt_idx;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_id_q  <= tail_id_q;
                    head_pay_q <= tail_pay_q;
                    head_src_q <= tail_src_q;
                    count_q    <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_id_q  <= push_id;
                        head_pay_q <= push_pay;
                        head_src_q <= gnt_idx;
                    end else begin
                        head_id_q  <= tail_id_q;
                        head_pay_q <= tail_pay_q;
                        head_src_q <= tail_src_q;
                        tail_id_q  <= push_id;
                        tail_pay_q <= push_pay;
                        tail_src_q <= gnt_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_intermediate_wb_arbiter.sv
// Bench for fp_intermediate_wb_arbiter: queue-based reference model plus directed literals.
module tb_fp_intermediate_wb_arbiter;
  localparam int N    = 3;
  localparam int ID_W = 3;
  localparam int PW   = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_intermediate_wb_arbiter_if #(.NUM_UNITS(N), .ID_W(ID_W), .PAYLOAD_W(PW)) bus ();

  fp_intermediate_wb_arbiter #(.NUM_UNITS(N), .ID_W(ID_W), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [PW-1:0]   pay;
    int              src;
  } ent_t;

  ent_t            q[$];
  int              ptr = 0;
  logic [N-1:0]    done_v = '0;
  logic [ID_W-1:0] id_v[N];
  logic [PW-1:0]   pay_v[N];
  logic            ready_v = 1'b0;
  logic [N-1:0]    last_ack = '0;

  logic [N-1:0]    ack_s;
  logic            valid_s;
  logic [ID_W-1:0] id_s;
  logic [1:0]      src_s;

  int vectors = 0;
  int miscompares = 0;
  int t2_ack[4];
  int t2_src[4];
  int t3_ack[5];
  int t3_hold_src;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.unit_done  = done_v;
    bus.norm_ready = ready_v;
    for (int k = 0; k < N; k++) begin
      bus.unit_id[k*ID_W +: ID_W]  = id_v[k];
      bus.unit_payload[k*PW +: PW] = pay_v[k];
    end
  endtask

  function automatic logic [PW-1:0] rand_pay();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_result(input int u);
    id_v[u]  = ID_W'($urandom);
    pay_v[u] = rand_pay();
  endtask

  // Expected ack: space exists and the first requesting unit from the start index wins
  function automatic logic [N-1:0] model_ack();
    bit space;
    int start;
    space = rst && ((q.size() < 2) || ready_v);
`ifdef FP_WB_ARB_FIXED_PRIORITY_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int i = 0; i < N; i++) begin
      int u;
      u = (start + i) % N;
      if (space && done_v[u]) return N'(1) << u;
    end
    return '0;
  endfunction

  task automatic step();
    logic [N-1:0] ea;
    @(negedge clk);
    ea      = model_ack();
    ack_s   = bus.unit_ack;
    valid_s = bus.norm_valid;
    id_s    = bus.norm_id;
    src_s   = bus.norm_src;
    chk("ack", bus.unit_ack, ea);
    chk("norm_valid", bus.norm_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("norm_id", bus.norm_id, q[0].id);
      chk("norm_payload", bus.norm_payload, q[0].pay);
      chk("norm_src", bus.norm_src, q[0].src);
    end
    last_ack = ea;
    @(posedge clk);
    if (q.size() > 0 && ready_v) void'(q.pop_front());
    for (int u = 0; u < N; u++) begin
      if (ea[u]) begin
        q.push_back('{id_v[u], pay_v[u], u});
        ptr = (u + 1) % N;
      end
    end
    #1;
  endtask

  task automatic refresh_acked();
    for (int u = 0; u < N; u++) if (last_ack[u]) new_result(u);
  endtask

  initial begin
`ifdef FP_WB_ARB_FIXED_PRIORITY_EN
    t2_ack = '{1, 1, 1, 1};
    t2_src = '{2, 0, 0, 0};
    t3_ack = '{1, 1, 0, 0, 1};
    t3_hold_src = 0;
`else
    t2_ack = '{1, 2, 4, 1};
    t2_src = '{2, 0, 1, 2};
    t3_ack = '{1, 2, 0, 0, 1};
    t3_hold_src = 1;
`endif
    for (int k = 0; k < N; k++) begin
      id_v[k]  = '0;
      pay_v[k] = '0;
    end
    done_v = 3'b111;
    drive();
    #1;
    chk("rst_valid", bus.norm_valid, 1'b0);
    chk("rst_ack", bus.unit_ack, '0);
    chk("rst_id", bus.norm_id, '0);
    chk("rst_payload", bus.norm_payload, '0);
    chk("rst_src", bus.norm_src, '0);
    done_v = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single request, same-cycle ack, next-cycle head
    done_v = 3'b001; id_v[0] = 3'd5; pay_v[0] = rand_pay(); ready_v = 1'b1;
    drive();
    step();
    chk("t1_ack", ack_s, 3'b001);
    done_v = '0;
    drive();
    step();
    chk("t1_valid", valid_s, 1'b1);
    chk("t1_id", id_s, 3'd5);
    chk("t1_src", src_s, 2'd0);

    // All requesting with ready high
    done_v = 3'b100; new_result(2); drive(); step();
    done_v = 3'b111;
    for (int k = 0; k < N; k++) new_result(k);
    drive();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t2_ack", ack_s, t2_ack[j]);
      chk("t2_src", src_s, t2_src[j]);
      refresh_acked(); drive();
    end

    // Fill with ready low, then resume
    done_v = 3'b100; new_result(2); drive(); step();
    done_v = '0; drive(); step(); step();
    ready_v = 1'b0; done_v = 3'b011; new_result(0); new_result(1); drive();
    for (int j = 0; j < 5; j++) begin
      if (j == 4) begin ready_v = 1'b1; drive(); end
      step();
      chk("t3_ack", ack_s, t3_ack[j]);
      if (j == 4) chk("t3_resume_src", src_s, 2'd0);
      refresh_acked(); drive();
    end
    ready_v = 1'b0; done_v = '0; drive();
    step();
    chk("t3_hold_src", src_s, t3_hold_src);

    // Full buffer: push and pop in the same cycle
    ready_v = 1'b1; done_v = 3'b100; new_result(2); drive();
    step();
    chk("t4_ack", ack_s, 3'b100);
    done_v = '0; drive();
    step();
    chk("t4_src_a", src_s, 2'd0);
    step();
    chk("t4_src_b", src_s, 2'd2);
    chk("t4_valid_b", valid_s, 1'b1);

    // Asynchronous reset with the buffer full
    ready_v = 1'b0; done_v = 3'b011; new_result(0); new_result(1); drive();
    step(); refresh_acked(); drive();
    step(); refresh_acked(); drive();
    #2;
    rst = 1'b0;
    #1;
    chk("t5_valid", bus.norm_valid, 1'b0);
    chk("t5_ack", bus.unit_ack, '0);
    chk("t5_id", bus.norm_id, '0);
    q.delete();
    ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    done_v = 3'b110; ready_v = 1'b1; drive();
    step();
    chk("t5_first_ack", ack_s, 3'b010);
    refresh_acked(); drive();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ready_v = ((c / 200) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int u = 0; u < N; u++) begin
        if (last_ack[u]) begin
          if ($urandom_range(0, 1) == 1) new_result(u);
          else done_v[u] = 1'b0;
        end else if (!done_v[u]) begin
          if ($urandom_range(0, 2) == 0) begin
            done_v[u] = 1'b1;
            new_result(u);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          done_v[u] = 1'b0;
        end
      end
      drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fp_intermediate_wb_arbiter.md
Name: fp_intermediate_wb_arbiter

Overview:
- Receiving end of the FP intermediate-writeback handshake (done/ack).
- Collects intermediate results from NUM_UNITS FP producers (mul, add, div/sqrt, …). Producers hold done high with stable payload until they see ack.
- Grants one producer per cycle, round-robin, and acks it. The accepted result goes into a 2-entry buffer, which feeds the shared normalization/rounding stage over a valid/ready interface.

Parameters:
- NUM_UNITS, 3, number of producer units (≥2)
- ID_W, 3, instruction id width
- PAYLOAD_W, 128, flattened intermediate-result width (rd, grs, rm, fflags, flags, shift amounts)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- unit_done  in  NUM_UNITS  per-unit result-valid; held until acked
- unit_id  in  NUM_UNITS*ID_W  per-unit id, unit k at [k*ID_W+:ID_W]
- unit_payload  in  NUM_UNITS*PAYLOAD_W  per-unit result, unit k at [k*PAYLOAD_W+:PAYLOAD_W]
- unit_ack  out  NUM_UNITS  one-hot accept strobe
- norm_valid  out  1  buffer head valid
- norm_ready  in  1  normalization stage accepts head
- norm_id  out  ID_W  head id
- norm_payload  out  PAYLOAD_W  head payload
- norm_src  out  $clog2(NUM_UNITS)  index of the unit that produced the head

Behaviour:
- Reset, while rst is low, asynchronously:
  - buffer count = 0, so norm_valid = 0.
  - RR pointer = 0.
  - norm_id, norm_payload and norm_src = 0.
  - unit_ack is forced to 0.
- Buffer: 2-entry FIFO. Head drives the norm_* outputs directly from registers, with no combinational path from unit inputs.
- pop = norm_valid & norm_ready.
- space = (count < 2) | pop. A simultaneous push and pop when full is legal and leaves count at 2.
- Grant:
  - Only when space is high.
  - Among the asserted unit_done bits, choose the first index ≥ pointer, wrapping modulo NUM_UNITS.
  - unit_ack for that unit is combinational in the same cycle. At most one ack bit is high per cycle.
  - If space is low, unit_ack = 0.
- Push: on the ack cycle, that unit's id, payload and index are written at the tail. Producers may present a new result in the cycle after ack.
- Pointer update: after a grant, pointer = granted+1, wrapping from NUM_UNITS-1 to 0. Without a grant the pointer holds.
- Latency: ack in cycle N gives norm_valid in cycle N+1 when the buffer was empty. With norm_ready tied high, sustained throughput is 1 result/cycle.
- Ordering: FIFO order is preserved. There is no reordering by id.
- norm_* are stable while norm_valid & ~norm_ready.
- Empty with pop=0: no change. count never exceeds 2 and never underflows. A pop on empty is impossible because norm_valid = 0.
- Deassertion of unit_done without an ack is tolerated. No state depends on it.
- Reset mid-operation discards buffered entries. Producers re-present because they saw no ack.

Optional Feature:
- Macro: FP_WB_ARB_FIXED_PRIORITY_EN.
- When defined:
  - The pointer register is removed.
  - The lowest-index asserted unit_done always wins, so unit 0 has highest priority. This suits low-latency units placed at low indices.
- When undefined: round-robin as specified above.
- Everything else (buffer, handshakes, reset) is identical in both builds.

Test Plan:
- Reset, then unit_done=3'b001, id=5, norm_ready=1 → unit_ack=3'b001 in the same cycle; next cycle norm_valid=1, norm_id=5, norm_src=0.
- unit_done=3'b111 held, norm_ready=1, RR build → acks 001, 010, 100, 001 on consecutive cycles; norm_src sequence 0,1,2,0.
- norm_ready=0, unit_done=3'b011 → two acks on consecutive cycles, then unit_ack=0 with count=2. Raise norm_ready → heads pop in accept order, and acks resume in the same cycle as the first pop.
- Buffer full, norm_ready=1, unit_done=3'b100 → ack and pop in the same cycle; count stays 2; payload order correct.
- Assert rst low with count=2 mid-stream → norm_valid=0 and unit_ack=0 immediately (before the next clk edge). After release, the first grant goes to the lowest asserted index ≥0.
- FP_WB_ARB_FIXED_PRIORITY_EN build, unit_done=3'b111 held for 3 cycles → acks 001, 001, 001, with units 1 and 2 starved.
